// File: rtl/mdc_output_reorder.sv
// Ping-pong reorder buffer. It collects the two-lane, bit-reversed FFT output stream
// and emits one natural-order sample per cycle, with valid/ready on both sides.
module mdc_output_reorder #(
  parameter  int DATA_WIDTH = 16,
  parameter  int N          = 8,
  localparam int LOGN       = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] x0,
  input  logic [DATA_WIDTH-1:0] x1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] y,
  output logic [LOGN-1:0]       out_index,
  output logic                  out_last
);

  localparam logic [LOGN-2:0] WR_LAST = '1;
  localparam logic [LOGN-1:0] RD_LAST = '1;

  logic [DATA_WIDTH-1:0] mem_q [2][N];

  logic [1:0]      full_q, full_d;
  logic            wr_bank_q, wr_bank_d;
  logic [LOGN-2:0] wr_cnt_q, wr_cnt_d;
  logic            rd_bank_q, rd_bank_d;
  logic [LOGN-1:0] rd_cnt_q, rd_cnt_d;

  logic            in_fire;
  logic            out_fire;
  logic [LOGN-1:0] wr_addr0;
  logic [LOGN-1:0] wr_addr1;

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] a);
    logic [LOGN-1:0] r;
    r = '0;
    for (int i = 0; i < LOGN; i++) r[i] = a[LOGN-1-i];
    return r;
  endfunction

  // Handshakes depend only on registered flags, so out_ready never reaches in_ready
  // and in_valid never reaches out_valid combinationally.
  always_comb begin
    in_ready  = ~full_q[wr_bank_q];
    out_valid = full_q[rd_bank_q];
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
    wr_addr0  = bitrev({wr_cnt_q, 1'b0});
    wr_addr1  = bitrev({wr_cnt_q, 1'b1});
    y         = out_valid ? mem_q[rd_bank_q][rd_cnt_q] : '0;
    out_index = out_valid ? rd_cnt_q : '0;
    out_last  = out_valid && (rd_cnt_q == RD_LAST);
  end

  // The draining bank and the filling bank always differ, so a fill completing
  // on the same edge as a drain touches the other flag.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_bank_d = rd_bank_q;
    rd_cnt_d  = rd_cnt_q;

    if (out_fire) begin
      if (rd_cnt_q == RD_LAST) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        rd_cnt_d          = '0;
      end else begin
        rd_cnt_d = rd_cnt_q + 1'b1;
      end
    end

    if (in_fire) begin
      if (wr_cnt_q == WR_LAST) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_cnt_d          = '0;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_bank_q <= 1'b0;
      rd_cnt_q  <= '0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_bank_q <= rd_bank_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end

  // Sample storage is not reset; the full flags alone decide what is readable.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem_q[wr_bank_q][wr_addr0] <= x0;
      mem_q[wr_bank_q][wr_addr1] <= x1;
    end
  end

endmodule

// File: tb/tb_mdc_output_reorder.sv
// Randomized bench for mdc_output_reorder: frames are generated in natural order,
// scrambled into bit-reversed pairs, and the output is checked against a frame queue.
module tb_mdc_output_reorder;

  localparam int DW   = 16;
  localparam int N    = 8;
  localparam int LOGN = $clog2(N);

  typedef struct {
    logic [DW-1:0] x0;
    logic [DW-1:0] x1;
    int            gap;
  } pair_t;

  typedef struct {
    logic [DW-1:0] y;
    int            idx;
    bit            last;
    int            cyc;
  } xfer_t;

  logic            clk       = 1'b0;
  logic            reset     = 1'b0;
  logic            in_valid  = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   x0        = '0;
  logic [DW-1:0]   x1        = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [DW-1:0]   y;
  logic [LOGN-1:0] out_index;
  logic            out_last;

  pair_t         drv_q[$];
  logic [DW-1:0] gen_nat[$];
  logic [DW-1:0] exp_q[$];
  xfer_t         xfer_log[$];

  int frames_done   = 0;
  int pair_cnt      = 0;
  int rd_idx        = 0;
  int cyc           = 0;
  int first_acc_cyc = 0;
  int last_acc_cyc  = 0;
  int n_cmp         = 0;
  int n_fail        = 0;
  int rdy_mode      = 0;
  bit chk_en        = 1'b0;
  bit exp_valid;
  bit exp_ready;

  mdc_output_reorder #(.DATA_WIDTH(DW), .N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x0        (x0),
    .x1        (x1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .out_index (out_index),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  function automatic int bitrev(input int v);
    int r;
    r = 0;
    for (int i = 0; i < LOGN; i++) r = (r << 1) | ((v >> i) & 1);
    return r;
  endfunction

  task automatic check_output(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Queue one frame: natural-order values are recorded for the model, pairs carry
  // the bit-reversed positions, and gap is the idle cycles before presenting a pair.
  task automatic apply_stimulus(input bit rand_data, input int gap_k, input int gap_len,
                                input bit rand_gaps);
    logic [DW-1:0] nat [N];
    pair_t p;
    for (int i = 0; i < N; i++) begin
      nat[i] = rand_data ? DW'($urandom) : DW'(i);
      gen_nat.push_back(nat[i]);
    end
    for (int k = 0; k < N/2; k++) begin
      p.x0  = nat[bitrev(2*k)];
      p.x1  = nat[bitrev(2*k+1)];
      p.gap = 0;
      if (k == gap_k) p.gap = gap_len;
      else if (rand_gaps && $urandom_range(0, 3) == 0) p.gap = int'($urandom_range(1, 2));
      drv_q.push_back(p);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((drv_q.size() > 0 || exp_q.size() > 0 || pair_cnt != 0) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_output(name, (n < budget) ? 1 : 0, 1);
  endtask

  // Literal expectations for a single frame holding 0..N-1.
  task automatic check_natural(input string tag, input int gap);
    check_output({tag, "_count"}, xfer_log.size(), N);
    if (xfer_log.size() == N) begin
      check_output({tag, "_latency"}, xfer_log[0].cyc - first_acc_cyc, N/2 + gap);
      check_output({tag, "_after_last_pair"}, xfer_log[0].cyc - last_acc_cyc, 1);
      for (int i = 0; i < N; i++) begin
        check_output({tag, "_y"}, xfer_log[i].y, i);
        check_output({tag, "_index"}, xfer_log[i].idx, i);
        check_output({tag, "_last"}, xfer_log[i].last, (i == N-1) ? 1 : 0);
        check_output({tag, "_cycle"}, xfer_log[i].cyc, xfer_log[0].cyc + i);
      end
    end
  endtask

  task automatic check_stream(input string tag, input int frames);
    int bubbles;
    int lasts;
    bubbles = 0;
    lasts   = 0;
    check_output({tag, "_count"}, xfer_log.size(), frames * N);
    for (int i = 0; i < xfer_log.size(); i++) begin
      if (i > 0 && xfer_log[i].cyc != xfer_log[i-1].cyc + 1) bubbles++;
      if (xfer_log[i].last) lasts++;
    end
    check_output({tag, "_bubbles"}, bubbles, 0);
    check_output({tag, "_lasts"}, lasts, frames);
  endtask

  task automatic model_flush();
    drv_q.delete();
    gen_nat.delete();
    exp_q.delete();
    frames_done = 0;
    pair_cnt    = 0;
    rd_idx      = 0;
  endtask

  // Driver: acceptance is sampled at the edge, new inputs are applied just after it.
  always @(posedge clk) begin
    bit acc;
    acc = in_valid && in_ready;
    #1;
    if (acc && drv_q.size() > 0) void'(drv_q.pop_front());
    if (drv_q.size() > 0 && drv_q[0].gap > 0) begin
      in_valid = 1'b0;
      drv_q[0].gap--;
    end else if (drv_q.size() > 0) begin
      in_valid = 1'b1;
      x0       = drv_q[0].x0;
      x1       = drv_q[0].x1;
    end else begin
      in_valid = 1'b0;
    end
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      2:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Model: a bank is readable once a whole frame is in; the source is blocked only
  // while two completed frames are still waiting to drain.
  always @(negedge clk) begin
    cyc++;
    if (chk_en && reset) begin
      exp_valid = (frames_done > 0);
      exp_ready = (frames_done < 2);
      check_output("in_ready", in_ready, exp_ready);
      check_output("out_valid", out_valid, exp_valid);
      if (out_valid && exp_valid && exp_q.size() > 0) begin
        check_output("y", y, exp_q[0]);
        check_output("out_index", out_index, rd_idx);
        check_output("out_last", out_last, (rd_idx == N-1) ? 1 : 0);
      end else if (!out_valid) begin
        check_output("y_idle", y, 0);
        check_output("out_index_idle", out_index, 0);
        check_output("out_last_idle", out_last, 0);
      end
      if (in_valid && in_ready) begin
        if (pair_cnt == 0) first_acc_cyc = cyc;
        last_acc_cyc = cyc;
        pair_cnt++;
        if (pair_cnt == N/2) begin
          pair_cnt = 0;
          frames_done++;
          for (int i = 0; i < N; i++)
            if (gen_nat.size() > 0) exp_q.push_back(gen_nat.pop_front());
        end
      end
      if (out_valid && out_ready && exp_q.size() > 0) begin
        xfer_t t;
        t.y    = y;
        t.idx  = int'(out_index);
        t.last = out_last;
        t.cyc  = cyc;
        xfer_log.push_back(t);
        void'(exp_q.pop_front());
        rd_idx++;
        if (rd_idx == N) begin
          rd_idx = 0;
          frames_done--;
        end
      end
    end
  end

  initial begin
    #200000;
    n_cmp++;
    n_fail++;
    $display("[TB] FAIL watchdog: simulation still running at t=%0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    bit found;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_in_ready", in_ready, 1);
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_y", y, 0);
    check_output("rst_out_index", out_index, 0);
    check_output("rst_out_last", out_last, 0);
    @(posedge clk);
    #2;
    reset  = 1'b1;
    chk_en = 1'b1;

    // Natural order: pairs (0,4) (2,6) (1,5) (3,7)
    rdy_mode = 1;
    xfer_log.delete();
    apply_stimulus(1'b0, -1, 0, 1'b0);
    wait_idle("nat_done", 200);
    check_natural("nat", 0);

    // Input gap of 3 cycles before pair k=2
    xfer_log.delete();
    apply_stimulus(1'b0, 2, 3, 1'b0);
    wait_idle("gap_done", 200);
    check_natural("gap", 3);

    // Ping-pong full with the sink stalled
    rdy_mode = 0;
    apply_stimulus(1'b1, -1, 0, 1'b0);
    apply_stimulus(1'b1, -1, 0, 1'b0);
    repeat (N + 6) @(negedge clk);
    #1;
    check_output("pp_in_ready_blocked", in_ready, 0);
    check_output("pp_out_valid_held", out_valid, 1);
    check_output("pp_all_pairs_taken", drv_q.size(), 0);
    xfer_log.delete();
    rdy_mode = 1;
    wait_idle("pp_done", 200);
    check_stream("pp", 2);

    // Backpressure toggling every cycle
    rdy_mode = 2;
    xfer_log.delete();
    for (int f = 0; f < 3; f++) apply_stimulus(1'b1, -1, 0, 1'b0);
    wait_idle("bp_done", 400);
    check_output("bp_count", xfer_log.size(), 3 * N);
    for (int i = 0; i < xfer_log.size(); i++) check_output("bp_index_order", xfer_log[i].idx, i % N);

    // Reset while frame 1 drains and frame 2 is partly written
    rdy_mode = 1;
    apply_stimulus(1'b1, -1, 0, 1'b0);
    apply_stimulus(1'b1, -1, 0, 1'b0);
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      #1;
      if (frames_done == 1 && pair_cnt == 2) found = 1'b1;
    end
    check_output("rstmid_reached", found, 1);
    @(posedge clk);
    #2;
    chk_en = 1'b0;
    reset  = 1'b0;
    #1;
    check_output("rstmid_out_valid", out_valid, 0);
    check_output("rstmid_in_ready", in_ready, 1);
    check_output("rstmid_y", y, 0);
    check_output("rstmid_out_last", out_last, 0);
    model_flush();
    repeat (3) @(posedge clk);
    #2;
    reset  = 1'b1;
    chk_en = 1'b1;
    xfer_log.delete();
    apply_stimulus(1'b0, -1, 0, 1'b0);
    wait_idle("rstmid_done", 200);
    check_natural("rstmid", 0);

    // Continuous back-to-back frames
    xfer_log.delete();
    for (int f = 0; f < 10; f++) apply_stimulus(1'b1, -1, 0, 1'b0);
    wait_idle("cont_done", 20 * N + 50);
    check_stream("cont", 10);

    // Random sink readiness and random source gaps
    rdy_mode = 3;
    xfer_log.delete();
    for (int f = 0; f < 6; f++) apply_stimulus(1'b1, -1, 0, 1'b1);
    wait_idle("rand_done", 1000);
    check_output("rand_count", xfer_log.size(), 6 * N);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
